mb8_word_ctl: RTL and testbench
===============================

# mb8_word_ctl

Bus initiator for the 8-bit single-port memory (128K x 8, `spram8_128k`-style responder on the mb8 byte bus). It accepts 1-, 2- or 4-byte read/write requests from a CPU-side valid/ready port and sequences them into consecutive byte accesses, little-endian. For reads it assembles the returned bytes into one 32-bit response. It sits between the eForth core's data path and the byte memory, and is the master end of the same bus the memory model responds to.

## Interface
Parameters:
- ASZ, 17, byte address width (128K).
- DSZ, 32, request/response data width; fixed to 4 byte lanes.

Ports:
- clk  in  1  system clock; everything in the block runs in this one domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_sz  in  2  00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
- req_ai  in  ASZ  starting byte address.
- req_vi  in  DSZ  write data; byte k is bits [8k+7:8k].
- rsp_valid  out  1  one-cycle pulse when the request completes.
- rsp_vo  out  DSZ  read data, valid with rsp_valid.
- mem_ai  out  ASZ  byte address to memory.
- mem_we  out  1  byte write strobe.
- mem_vi  out  8  byte written to memory.
- mem_vo  in  8  byte read from memory; valid the cycle after its address is presented.

## Operation
- States: IDLE, XFER, DRAIN, DONE.
- IDLE: req_ready=1. On req_valid=1, latch we, N (1/2/4), address, write data. Clear the byte counter k and the read assembly register. Go to XFER.
- XFER: each cycle drive mem_ai = base+k (mod 2^ASZ), mem_we = we, mem_vi = byte k of the latched data. Increment k.
  - After byte N-1: writes go to DONE; reads go to DRAIN.
- Read capture: the byte returned by mem_vo in the cycle after address base+k goes into lane k of the assembly register.
- DRAIN (reads only): one cycle to capture the final byte. mem_we=0 and mem_ai holds its last value. Then go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then back to IDLE.
  - rsp_vo = assembled data for reads, with lanes >= N zero.
  - rsp_vo = 0 for writes.
- Address arithmetic is ASZ bits wide and wraps: 0x1FFFF+1 = 0x00000. There is no error for wrapping.
- req_ready=0 in every state except IDLE. req_valid is ignored outside IDLE. There is no response backpressure.
- mem_we is 1 only in XFER with we=1.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_vo=0, mem_ai=0, mem_we=0, mem_vi=0. State = IDLE.
- Reset asserted mid-transfer aborts it immediately:
  - no further mem_we, no rsp_valid;
  - bytes already written stay written.
- Request accepted at edge E0. Byte k is on the mem bus in cycle E0+1+k.
- Write latency: rsp_valid in cycle E0+N+1. Next request can be accepted at edge E0+N+2.
- Read latency: rsp_valid in cycle E0+N+2. Next request can be accepted at edge E0+N+3.
- Throughput:
  - 4-byte write: one request per 6 cycles.
  - 4-byte read: one request per 7 cycles.
- All outputs are registered. No combinational path from mem_vo or req_* to any output.
- mem_ai and mem_vi hold their last values in IDLE and DONE.

## Test plan
- After reset, check all outputs at their reset values. Then issue a write of 0xDDCCBBAA, sz=10, at 0x00100. Required: bytes AA, BB, CC, DD go to 0x00100..0x00103 on consecutive cycles with mem_we=1, and rsp_valid appears 5 cycles after accept.
- Read back the same word, sz=10. Required: rsp_vo=0xDDCCBBAA with rsp_valid 6 cycles after accept. Confirm req_ready was 0 throughout.
- 1-byte read at 0x00102 → rsp_vo=0x000000CC. 2-byte read at 0x00101 → rsp_vo=0x0000CCBB.
- Wrap: 4-byte write of 0x44332211 at 0x1FFFE. Required: addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001. A read at 0x1FFFE then returns 0x44332211.
- Assert rst during byte 2 of a 4-byte write. Required: mem_we drops immediately and no rsp_valid appears. After release, memory holds only bytes 0–1 of the new data and byte 2+ of the old data; req_ready=1.
- Hold req_valid high continuously with alternating write and read requests. Required: each is accepted exactly once, at the cycle after rsp_valid, and no request is dropped or duplicated.

Source files
------------

// File: rtl/mb8_word_ctl.sv
// Byte-bus initiator: splits 1/2/4-byte CPU requests into little-endian byte
// accesses on the mb8 bus and assembles read bytes into one 32-bit response.
module mb8_word_ctl #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_sz,
  input  logic [ASZ-1:0] req_ai,
  input  logic [DSZ-1:0] req_vi,
  output logic           rsp_valid,
  output logic [DSZ-1:0] rsp_vo,
  output logic [ASZ-1:0] mem_ai,
  output logic           mem_we,
  output logic [7:0]     mem_vi,
  input  logic [7:0]     mem_vo
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t         state_q;
  logic           we_q;
  logic [2:0]     n_q;
  logic [2:0]     k_q;
  logic [ASZ-1:0] base_q;
  logic [DSZ-1:0] wdata_q;
  logic [DSZ-1:0] asm_q;
  logic           req_ready_q;
  logic           rsp_valid_q;
  logic [DSZ-1:0] rsp_vo_q;
  logic [ASZ-1:0] mem_ai_q;
  logic           mem_we_q;
  logic [7:0]     mem_vi_q;

  logic [2:0]     n_d;
  logic [ASZ-1:0] addr_d;
  logic [7:0]     byte_d;
  logic [2:0]     lane_d;
  logic [DSZ-1:0] asm_d;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_vo    = rsp_vo_q;
  assign mem_ai    = mem_ai_q;
  assign mem_we    = mem_we_q;
  assign mem_vi    = mem_vi_q;

  always_comb begin
    n_d = 3'd4;
    if (req_sz == 2'b00) n_d = 3'd1;
    else if (req_sz == 2'b01) n_d = 3'd2;
  end

  assign addr_d = base_q + ASZ'(k_q);
  assign byte_d = wdata_q[8*k_q[1:0] +: 8];

  // Read data lags its address by one cycle and is sampled one edge later,
  // so the lane landing now is k-2 in XFER and the final lane k-1 in DRAIN.
  always_comb begin
    asm_d  = asm_q;
    lane_d = (state_q == DRAIN) ? (k_q - 3'd1) : (k_q - 3'd2);
    if (!we_q && ((state_q == DRAIN) || ((state_q == XFER) && (k_q >= 3'd2))))
      asm_d[8*lane_d[1:0] +: 8] = mem_vo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      n_q         <= 3'd0;
      k_q         <= 3'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_vo_q    <= '0;
      mem_ai_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_vi_q    <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            n_q         <= n_d;
            base_q      <= req_ai;
            wdata_q     <= req_vi;
            asm_q       <= '0;
            // Byte 0 goes out on the accept edge, so the counter resumes at 1.
            k_q         <= 3'd1;
            mem_ai_q    <= req_ai;
            mem_we_q    <= req_we;
            mem_vi_q    <= req_vi[7:0];
            req_ready_q <= 1'b0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          asm_q <= asm_d;
          if (k_q == n_q) begin
            mem_we_q <= 1'b0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_vo_q    <= '0;
              state_q     <= DONE;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            mem_ai_q <= addr_d;
            mem_vi_q <= byte_d;
            k_q      <= k_q + 3'd1;
          end
        end
        DRAIN: begin
          asm_q       <= asm_d;
          rsp_valid_q <= 1'b1;
          rsp_vo_q    <= asm_d;
          state_q     <= DONE;
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb8_word_ctl.sv
// Self-checking bench for mb8_word_ctl: a byte memory model on the bus,
// a response scoreboard, table-driven requests and hand-written corner cases.
module tb_mb8_word_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_sz = 2'b00;
  logic [16:0] req_ai = '0;
  logic [31:0] req_vi = '0;
  logic        rsp_valid;
  logic [31:0] rsp_vo;
  logic [16:0] mem_ai;
  logic        mem_we;
  logic [7:0]  mem_vi;
  logic [7:0]  mem_vo;

  logic [7:0]  memArr [0:131071];
  logic [31:0] expQ [$];
  int          checks = 0;
  int          errors = 0;
  int          rspCount = 0;

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    logic [16:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  mb8_word_ctl #(.ASZ(17), .DSZ(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sz(req_sz), .req_ai(req_ai), .req_vi(req_vi),
    .rsp_valid(rsp_valid), .rsp_vo(rsp_vo),
    .mem_ai(mem_ai), .mem_we(mem_we), .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  always #5 clk = ~clk;

  // Byte memory responder: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) memArr[mem_ai] <= mem_vi;
    mem_vo <= memArr[mem_ai];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rspCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRsp: got rsp_valid=1 with rsp_vo=0x%08h, expected no response", rsp_vo);
      end else begin
        checkOutput("rspData", rsp_vo, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit we, input logic [1:0] sz, input logic [16:0] addr,
                               input logic [31:0] data, input logic [31:0] exp);
    int n;
    int lat;
    bit seen;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lat  = we ? n : n + 1;
    seen = 1'b0;
    @(negedge clk);
    checkOutput("readyBefore", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_sz    = sz;
    req_ai    = addr;
    req_vi    = data;
    expQ.push_back(exp);
    for (int c = 0; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
      if (c < n) begin
        checkOutput("memAddr", mem_ai, (addr + c) & 32'h1FFFF);
        checkOutput("memWe", mem_we, we);
        if (we) checkOutput("memData", mem_vi, data[8*c +: 8]);
      end else begin
        checkOutput("memWeOff", mem_we, 0);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        checkOutput("latency", c, lat);
      end else begin
        checkOutput("readyBusy", req_ready, 0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL rspTimeout: got no rsp_valid within 20 cycles, expected one");
    end
    @(negedge clk);
    checkOutput("rspPulse", rsp_valid, 0);
    checkOutput("readyIdle", req_ready, 1);
  endtask

  initial begin
    int w;
    int c;
    int startCount;
    logic [31:0] pairData;

    vecs[0] = '{1'b1, 2'b10, 17'h00100, 32'hDDCCBBAA, 32'h00000000};
    vecs[1] = '{1'b0, 2'b10, 17'h00100, 32'h0,        32'hDDCCBBAA};
    vecs[2] = '{1'b0, 2'b00, 17'h00102, 32'h0,        32'h000000CC};
    vecs[3] = '{1'b0, 2'b01, 17'h00101, 32'h0,        32'h0000CCBB};
    vecs[4] = '{1'b1, 2'b10, 17'h1FFFE, 32'h44332211, 32'h00000000};
    vecs[5] = '{1'b0, 2'b10, 17'h1FFFE, 32'h0,        32'h44332211};
    vecs[6] = '{1'b1, 2'b00, 17'h00100, 32'h12345677, 32'h00000000};
    vecs[7] = '{1'b0, 2'b11, 17'h00100, 32'h0,        32'hDDCCBB77};
    vecs[8] = '{1'b1, 2'b01, 17'h1FFFF, 32'hFFFF9988, 32'h00000000};
    vecs[9] = '{1'b0, 2'b10, 17'h1FFFE, 32'h0,        32'h44998811};

    repeat (2) @(negedge clk);
    checkOutput("rstReady", req_ready, 1);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstRspVo", rsp_vo, 0);
    checkOutput("rstMemAi", mem_ai, 0);
    checkOutput("rstMemWe", mem_we, 0);
    checkOutput("rstMemVi", mem_vi, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].data, vecs[i].exp);

    // Reset during byte 2 of a 4-byte write over known old data.
    applyStimulus(1'b1, 2'b10, 17'h00300, 32'h88776655, 32'h0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_sz    = 2'b10;
    req_ai    = 17'h00300;
    req_vi    = 32'h0D0C0B0A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abortAddr", mem_ai, 32'h00302);
    checkOutput("abortWeBefore", mem_we, 1);
    rst = 1'b1;
    #1;
    checkOutput("abortWeDrop", mem_we, 0);
    checkOutput("abortRsp", rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abortReady", req_ready, 1);
    applyStimulus(1'b0, 2'b10, 17'h00300, 32'h0, 32'h88770B0A);

    // Back-to-back requests with req_valid held high throughout.
    startCount = rspCount;
    @(negedge clk);
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pairData = {8'h10 + 8'(i/2), 8'h20 + 8'(i/2), 8'h30 + 8'(i/2), 8'h40 + 8'(i/2)};
      req_we = (i % 2 == 0);
      req_sz = 2'b10;
      req_ai = 17'h00200 + 17'(4 * (i/2));
      req_vi = pairData;
      expQ.push_back((i % 2 == 0) ? 32'h0 : pairData);
      w = 0;
      while (!req_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      checkOutput("contReadyWait", w, (i == 0) ? 0 : 1);
      @(negedge clk);
      checkOutput("contAccepted", req_ready, 0);
      c = 0;
      while (!rsp_valid && c < 20) begin
        @(negedge clk);
        c++;
      end
      checkOutput("contLatency", c, (i % 2 == 0) ? 4 : 5);
    end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("contRspCount", rspCount - startCount, 6);
    checkOutput("contQueueEmpty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
